// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- 16-way round-robin arbiter with an IDLE/GRANT/RELEASE FSM.
// The owner index (sel) and decoder enable (en) are registered; gnt is the
// 4-to-16 decode of sel gated by en.
// Optional feature macro: ARB_TIMEOUT_EN adds a 4-bit hold counter that
// forces release after MAX_HOLD grant cycles and pulses timeout. Without the
// macro the grant is held until done or the owner's request drops.
module rr_arbiter16 #(
    parameter int MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic        en,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // The hold counter is 4 bits, so the limit must fit 1..15.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
        $error("rr_arbiter16: MAX_HOLD must be in 1..15");
    end

    logic [1:0] state;
    logic [3:0] ptr;
    logic [3:0] pick;
    logic [3:0] idx;
    logic       drop;
    logic       leave;

    // Owner asked to give up the grant: finished, or stopped requesting.
    assign drop = done | ~req[sel];

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_cnt;
    logic       limit;

    // Current GRANT cycle is the last one allowed for this owner.
    assign limit = (hold_cnt == 4'(MAX_HOLD - 1));
    assign leave = drop | limit;

    // Hold counter sits at zero outside GRANT, counts grant cycles and
    // saturates instead of wrapping; timeout flags a limit-only release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 4'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == GRANT) && limit && !drop;
            if (state != GRANT) begin
                hold_cnt <= 4'd0;
            end else if (hold_cnt != 4'hF) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end
`else
    assign leave   = drop;
    assign timeout = 1'b0;
`endif

    // Circular search for the first requester at or after ptr; scanning
    // offsets from high to low lets the smallest offset win.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    // Main FSM: arbitrate in IDLE, hold in GRANT, one dead cycle in RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 4'd0;
            sel   <= 4'd0;
            en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= pick;
                        en    <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (leave) begin
                        en    <= 1'b0;
                        ptr   <= sel + 4'd1;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    en    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = en ? (16'd1 << sel) : 16'd0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16 -- directed scenarios plus randomized req/done traffic
// checked against a behavioural round-robin model. Honours ARB_TIMEOUT_EN.
module tb_rr_arbiter16;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'd0;
    logic        done = 1'b0;
    logic [3:0]  sel;
    logic        en;
    logic [15:0] gnt;
    logic        busy;
    logic        timeout;

    always #5 clk = ~clk;

    rr_arbiter16 #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 owner holds grant, 2 release gap.
    int m_phase, m_owner, m_ptr, m_held;
    bit m_to;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic d);
        bit quit, lim, found;
        m_to = 0;
        case (m_phase)
            1: begin
                m_held++;
                quit = d || !r[m_owner];
                lim  = TO_EN && (m_held >= HOLD);
                if (quit || lim) begin
                    m_phase = 2;
                    m_ptr   = (m_owner + 1) % 16;
                    m_to    = lim && !quit;
                end
            end
            2: m_phase = 0;
            default: begin
                if (r != 16'd0) begin
                    found = 0;
                    for (int k = 0; k < 16; k++) begin
                        if (!found && r[(m_ptr + k) % 16]) begin
                            m_owner = (m_ptr + k) % 16;
                            found = 1;
                        end
                    end
                    m_phase = 1;
                    m_held  = 0;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("m_gnt", 32'(gnt), (m_phase == 1) ? 32'(1 << m_owner) : 32'd0);
        chk("m_sel", 32'(sel), 32'(m_owner));
        chk("m_en", 32'(en), 32'(m_phase == 1));
        chk("m_busy", 32'(busy), 32'(m_phase != 0));
        chk("m_timeout", 32'(timeout), 32'(m_to));
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 16'd0;
        done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int  waitc[16];
    int  maxw;
    logic prev_en;

    initial begin
        // Reset state
        apply_reset();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // Single requester grant and release
        req = 16'h0001; tick();
        chk("one_sel", 32'(sel), 32'd0);
        chk("one_en", 32'(en), 32'd1);
        chk("one_gnt", 32'(gnt), 32'h0001);
        chk("one_busy", 32'(busy), 32'd1);
        done = 1'b1; tick();
        chk("one_rel_en", 32'(en), 32'd0);
        chk("one_rel_gnt", 32'(gnt), 32'd0);
        chk("one_rel_busy", 32'(busy), 32'd1);
        done = 1'b0; req = 16'd0; tick();
        chk("one_idle_busy", 32'(busy), 32'd0);

        // Alternation between 0 and 15 with pointer wrap
        apply_reset();
        req = 16'h8001; tick();
        chk("rr_a_sel", 32'(sel), 32'd0);
        chk("rr_a_en", 32'(en), 32'd1);
        done = 1'b1; tick(); done = 1'b0;
        chk("rr_gap1_en", 32'(en), 32'd0);
        tick();
        chk("rr_gap2_en", 32'(en), 32'd0);
        tick();
        chk("rr_b_sel", 32'(sel), 32'd15);
        chk("rr_b_en", 32'(en), 32'd1);
        done = 1'b1; tick(); done = 1'b0;
        chk("rr_gap3_en", 32'(en), 32'd0);
        tick();
        chk("rr_gap4_en", 32'(en), 32'd0);
        tick();
        chk("rr_c_sel", 32'(sel), 32'd0);
        chk("rr_c_gnt", 32'(gnt), 32'h0001);

        // Hold limit
        apply_reset();
        req = 16'h0010;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < HOLD; k++) begin
            tick();
            chk("hold_gnt", 32'(gnt), 32'h0010);
            chk("hold_to", 32'(timeout), 32'd0);
        end
        tick();
        chk("limit_gnt", 32'(gnt), 32'd0);
        chk("limit_to", 32'(timeout), 32'd1);
        tick();
        chk("limit_to_pulse", 32'(timeout), 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold_gnt", 32'(gnt), 32'h0010);
            chk("hold_to", 32'(timeout), 32'd0);
        end
`endif
        req = 16'd0; tick(); tick();

        // Owner 3 drops request together with done
        apply_reset();
        req = 16'h0008; tick();
        chk("drop_sel", 32'(sel), 32'd3);
        req = 16'd0; done = 1'b1; tick();
        chk("drop_en", 32'(en), 32'd0);
        chk("drop_to", 32'(timeout), 32'd0);
        chk("drop_busy", 32'(busy), 32'd1);
        done = 1'b0; req = 16'hFFFF; tick();
        chk("drop_rel_en", 32'(en), 32'd0);
        chk("drop_rel_to", 32'(timeout), 32'd0);
        tick();
        chk("drop_ptr_sel", 32'(sel), 32'd4);

        // Asynchronous reset in the middle of a grant to 7
        req = 16'h0080; done = 1'b1; tick(); done = 1'b0;
        tick(); tick();
        chk("mid_sel", 32'(sel), 32'd7);
        chk("mid_gnt", 32'(gnt), 32'h0080);
        rst = 1'b1; #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_en", 32'(en), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 16'hFFFF; tick();
        chk("post_rst_sel", 32'(sel), 32'd0);
        chk("post_rst_en", 32'(en), 32'd1);

        // Randomized traffic against the model
        apply_reset();
        maxw = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 16; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 9) == 0) req = 16'd0;
                else req = 16'($urandom) & 16'($urandom);
            end
            done = ($urandom_range(0, 3) == 0);
            tick();
            model_step(req, done);
            check_model();
            if (en && !prev_en) begin
                for (int i = 0; i < 16; i++) begin
                    if (i == int'(sel)) waitc[i] = 0;
                    else if (req[i]) waitc[i]++;
                end
            end
            for (int i = 0; i < 16; i++) begin
                if (!req[i]) waitc[i] = 0;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            prev_en = en;
        end
        chk("fairness", 32'(maxw <= 15), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, meaning max cycles one grant is held before forced release (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port req  input  16  request vector; bit i = requester i.
REQ-005 SHALL have port done  input  1  current owner finished; sampled only in GRANT.
REQ-006 SHALL have port sel  output  4  registered index of current owner; drives the 4-to-16 decoder select.
REQ-007 SHALL have port en  output  1  registered decoder enable; 1 only in GRANT.
REQ-008 SHALL have port gnt  output  16  one-hot grant = decode(sel) when en=1, else all zero.
REQ-009 SHALL have port busy  output  1  1 whenever state != IDLE.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-012 IDLE: when req != 0 at a clock edge, SHALL load sel with the first set bit at or after ptr, searched circularly 15->0, and enter GRANT; gnt visible one cycle after req is sampled.
REQ-013 IDLE with req == 0 SHALL remain in IDLE; sel holds its last value, en=0.
REQ-014 GRANT SHALL hold sel and en=1 while req[sel]=1, done=0 and hold count < MAX_HOLD.
REQ-015 GRANT SHALL exit to RELEASE on done=1, req[sel]=0, or hold count reaching MAX_HOLD; en clears on that edge.
REQ-016 Simultaneous done=1 and req[sel]=0 SHALL cause one release only; timeout SHALL NOT pulse unless the hold limit is the cause.
REQ-017 On every exit from GRANT, ptr SHALL load sel+1 modulo 16 (15 wraps to 0).
REQ-018 RELEASE SHALL last exactly one cycle, then go to IDLE; new arbitration happens in IDLE, so back-to-back grants are separated by 2 cycles with en=0.
REQ-019 Hold counter is 4 bits; it clears on entry to GRANT and increments each GRANT cycle; it SHALL NOT wrap.
REQ-020 Requests that change while in GRANT or RELEASE SHALL NOT affect sel until the next IDLE arbitration.
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, ptr=0, sel=0, en=0, gnt=0, busy=0, timeout=0 and hold count=0, with no clock edge needed.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt at once; after release the first arbitration SHALL start from ptr=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: the hold-limit exit (REQ-015) and the timeout pulse SHALL be implemented.
REQ-025 Macro ARB_TIMEOUT_EN undefined: the hold counter SHALL be omitted, GRANT SHALL exit only on done or req drop, and timeout SHALL be tied to 0.

Verification
REQ-026 Reset, then req=16'h0001 -> next edge sel=0, en=1, gnt=16'h0001, busy=1; done=1 -> next edge en=0, gnt=0; then busy=0 after RELEASE.
REQ-027 req=16'h8001 held, done pulsed each grant -> grants alternate sel=0, sel=15, sel=0 (ptr wraps 15->0), 2 idle-enable cycles between grants.
REQ-028 ARB_TIMEOUT_EN, MAX_HOLD=4, req=16'h0010 held, done=0 -> gnt=16'h0010 for 4 cycles, then timeout=1 for 1 cycle; without the macro the grant holds indefinitely.
REQ-029 Owner sel=3 drops req[3] while done=1 in the same cycle -> single release, timeout=0, ptr=4.
REQ-030 rst pulsed mid-GRANT (sel=7) without a clock edge -> gnt=0, en=0 immediately; after release, req=16'hFFFF -> sel=0.
REQ-031 Random req/done for 10k cycles -> gnt is always one-hot or zero, and every continuously requesting requester is granted within 16 grants.
